uart_cmd_ctrl: RTL and testbench

- Command sequencer between the UART receive path and the system's register file, ALU and UART transmit FIFO.
- Consumes validated RX bytes, decodes a byte-oriented command protocol, and issues register-file writes and reads plus ALU operations.
- Queues response bytes to the TX FIFO.
- Gates the ALU clock so the ALU runs only while an ALU command is in flight.

---
 rtl/uart_cmd_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes RX command bytes (AA wr, BB rd, CC alu+operands, DD alu) into RF/ALU strobes, queues responses to TX, gates ALU clock
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic                    RX_ERR,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_Valid,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLKG_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_FULL
);
  localparam int CW = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(RSP_TIMEOUT - 1);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A, S_OP_B,
    S_ALU_FUN, S_ALU_WAIT, S_TX_BYTE0, S_TX_BYTE1
  } state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rf_addr_d;
  logic [2*DATA_WIDTH-1:0] rsp_q, rsp_d;
  logic alu_q, alu_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_en_d, rd_en_d, alu_en_d, clkg_d, tx_vld_d;
  logic [DATA_WIDTH-1:0] wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0] fun_d;
  logic collecting;
  assign collecting = state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OP_A, S_OP_B, S_ALU_FUN};
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    rsp_d     = rsp_q;
    alu_d     = alu_q;
    cnt_d     = '0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    rf_addr_d = RF_Address;
    wr_data_d = RF_WrData;
    fun_d     = ALU_FUN;
    tx_data_d = TX_P_DATA;
    if (collecting && RX_ERR) state_d = S_IDLE;
    else case (state)
      S_IDLE: if (RX_D_VLD)
        state_d = RX_P_DATA == DATA_WIDTH'(8'hAA) ? S_WR_ADDR :
                  RX_P_DATA == DATA_WIDTH'(8'hBB) ? S_RD_ADDR :
                  RX_P_DATA == DATA_WIDTH'(8'hCC) ? S_OP_A :
                  RX_P_DATA == DATA_WIDTH'(8'hDD) ? S_ALU_FUN : S_IDLE;
      S_WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        rf_addr_d = addr_q;
        wr_data_d = RX_P_DATA;
        state_d   = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        rd_en_d   = 1'b1;
        rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: if (RF_RdData_Valid) begin
        rsp_d   = {{DATA_WIDTH{1'b0}}, RF_RdData};
        alu_d   = 1'b0;
        state_d = S_TX_BYTE0;
      end else if (cnt_q == TO_LAST) state_d = S_IDLE;
      else cnt_d = cnt_q + 1'b1;
      S_OP_A, S_OP_B: if (RX_D_VLD) begin
        wr_en_d   = 1'b1;
        rf_addr_d = state == S_OP_A ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
        wr_data_d = RX_P_DATA;
        state_d   = state == S_OP_A ? S_OP_B : S_ALU_FUN;
      end
      S_ALU_FUN: if (RX_D_VLD) begin
        alu_en_d = 1'b1;
        fun_d    = RX_P_DATA[FUN_WIDTH-1:0];
        state_d  = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (ALU_OUT_VLD) begin
        rsp_d   = ALU_OUT;
        alu_d   = 1'b1;
        state_d = S_TX_BYTE0;
      end else if (cnt_q == TO_LAST) state_d = S_IDLE;
      else cnt_d = cnt_q + 1'b1;
      S_TX_BYTE0: if (!TX_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rsp_q[DATA_WIDTH-1:0];
        state_d   = alu_q ? S_TX_BYTE1 : S_IDLE;
      end
      S_TX_BYTE1: if (!TX_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rsp_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    clkg_d = state_d inside {S_OP_A, S_OP_B, S_ALU_FUN, S_ALU_WAIT};
    if (state_d == S_IDLE) fun_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      rsp_q      <= '0;
      alu_q      <= 1'b0;
      cnt_q      <= '0;
      RF_Address <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_WrData  <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLKG_EN    <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      rsp_q      <= rsp_d;
      alu_q      <= alu_d;
      cnt_q      <= cnt_d;
      RF_Address <= rf_addr_d;
      RF_WrEn    <= wr_en_d;
      RF_RdEn    <= rd_en_d;
      RF_WrData  <= wr_data_d;
      ALU_EN     <= alu_en_d;
      ALU_FUN    <= fun_d;
      CLKG_EN    <= clkg_d;
      TX_P_DATA  <= tx_data_d;
      TX_D_VLD   <= tx_vld_d;
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed vector table plus timeout/reset sequences for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic RX_D_VLD = 1'b0, RX_ERR = 1'b0, RF_RdData_Valid = 1'b0, ALU_OUT_VLD = 1'b0, TX_FULL = 1'b0;
  logic [7:0] RF_RdData = '0;
  logic [15:0] ALU_OUT = '0;
  logic [3:0] RF_Address, ALU_FUN;
  logic [7:0] RF_WrData, TX_P_DATA;
  logic RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, TX_D_VLD;
  always #5 clk = ~clk;
  uart_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .CLKG_EN(CLKG_EN), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .TX_FULL(TX_FULL)
  );
  typedef struct {
    logic [2:0]  ctl;
    logic [7:0]  rx;
    logic [1:0]  rsp;
    logic [15:0] dat;
    logic [4:0]  strb;
    logic [3:0]  addr;
    logic [7:0]  wd;
    logic [3:0]  fun;
    logic [7:0]  td;
  } vec_t;
  vec_t vecs[$];
  int tests = 0;
  int fails = 0;
  function automatic void a(input logic [2:0] c, input logic [7:0] r, input logic [1:0] s,
                            input logic [15:0] d, input logic [4:0] st, input logic [3:0] ad,
                            input logic [7:0] w, input logic [3:0] f, input logic [7:0] t);
    vec_t x;
    x.ctl = c; x.rx = r; x.rsp = s; x.dat = d; x.strb = st;
    x.addr = ad; x.wd = w; x.fun = f; x.td = t;
    vecs.push_back(x);
  endfunction
  task automatic drive(input logic [2:0] c, input logic [7:0] r, input logic [1:0] s, input logic [15:0] d);
    @(negedge clk);
    {RX_D_VLD, RX_ERR, TX_FULL} = c;
    RX_P_DATA = r;
    {RF_RdData_Valid, ALU_OUT_VLD} = s;
    RF_RdData = d[7:0];
    ALU_OUT = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  function automatic logic [31:0] all_outs();
    return {3'b0, RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLKG_EN, TX_P_DATA, TX_D_VLD};
  endfunction
  initial begin
    logic ok;
    logic [4:0] strb;
    int n, bad;
    // strb = {RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, TX_D_VLD}; ctl = {RX_D_VLD, RX_ERR, TX_FULL}
    a(3'b100, 8'hAA, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h05, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h3C, 2'b00, 16'h0, 5'b10000, 4'h5, 8'h3C, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'hBB, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h05, 2'b00, 16'h0, 5'b01000, 4'h5, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b10, 16'h003C, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00001, 4'h0, 8'h00, 4'h0, 8'h3C);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'hCC, 2'b00, 16'h0, 5'b00010, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h10, 2'b00, 16'h0, 5'b10010, 4'h0, 8'h10, 4'h0, 8'h00);
    a(3'b100, 8'h20, 2'b00, 16'h0, 5'b10010, 4'h1, 8'h20, 4'h0, 8'h00);
    a(3'b100, 8'h00, 2'b00, 16'h0, 5'b00110, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00010, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b01, 16'h0030, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00001, 4'h0, 8'h00, 4'h0, 8'h30);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00001, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'hAA, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h05, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b110, 8'h77, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'hAA, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h06, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h11, 2'b00, 16'h0, 5'b10000, 4'h6, 8'h11, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b010, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h55, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'hDD, 2'b00, 16'h0, 5'b00010, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b100, 8'h02, 2'b00, 16'h0, 5'b00110, 4'h0, 8'h00, 4'h2, 8'h00);
    a(3'b100, 8'hAA, 2'b00, 16'h0, 5'b00010, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b001, 8'h00, 2'b01, 16'hBEEF, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    for (int i = 0; i < 10; i++) a(3'b001, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00001, 4'h0, 8'h00, 4'h0, 8'hEF);
    a(3'b101, 8'hCC, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b001, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00001, 4'h0, 8'h00, 4'h0, 8'hBE);
    a(3'b000, 8'h00, 2'b00, 16'h0, 5'b00000, 4'h0, 8'h00, 4'h0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].rx, vecs[i].rsp, vecs[i].dat);
      strb = {RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN, TX_D_VLD};
      ok = strb === vecs[i].strb
        && (!(vecs[i].strb[4] || vecs[i].strb[3]) || RF_Address === vecs[i].addr)
        && (!vecs[i].strb[4] || RF_WrData === vecs[i].wd)
        && (!vecs[i].strb[2] || ALU_FUN === vecs[i].fun)
        && (!vecs[i].strb[0] || TX_P_DATA === vecs[i].td);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL vec%0d got strb=%b addr=%h wd=%h fun=%h td=%h exp strb=%b addr=%h wd=%h fun=%h td=%h",
                 i, strb, RF_Address, RF_WrData, ALU_FUN, TX_P_DATA,
                 vecs[i].strb, vecs[i].addr, vecs[i].wd, vecs[i].fun, vecs[i].td);
      end
    end
    drive(3'b100, 8'hBB, 2'b00, 16'h0);
    drive(3'b100, 8'h03, 2'b00, 16'h0);
    chk("to_rd_en", {RF_RdEn, RF_Address}, {1'b1, 4'h3});
    bad = 0;
    repeat (254) begin
      drive(3'b000, 8'h00, 2'b00, 16'h0);
      if (RF_WrEn || RF_RdEn || ALU_EN || TX_D_VLD || CLKG_EN) bad++;
    end
    chk("to_rd_quiet", bad, 0);
    drive(3'b100, 8'hDD, 2'b00, 16'h0);
    chk("to_rd_last_drop", CLKG_EN, 1'b0);
    drive(3'b100, 8'hDD, 2'b00, 16'h0);
    chk("to_rd_idle_accept", CLKG_EN, 1'b1);
    drive(3'b100, 8'h07, 2'b00, 16'h0);
    chk("to_alu_en", {ALU_EN, CLKG_EN, ALU_FUN}, {1'b1, 1'b1, 4'h7});
    n = 0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive(3'b000, 8'h00, 2'b00, 16'h0);
      if (TX_D_VLD) bad++;
      if (!CLKG_EN) break;
      n++;
    end
    chk("to_alu_clkg_cycles", n, 254);
    chk("to_alu_no_tx", bad, 0);
    drive(3'b000, 8'h00, 2'b00, 16'h0);
    chk("to_alu_idle_quiet", all_outs() & 32'h0C0_0201, 32'h0);
    drive(3'b100, 8'hDD, 2'b00, 16'h0);
    drive(3'b100, 8'h09, 2'b00, 16'h0);
    chk("rst_pre_alu_en", {ALU_EN, CLKG_EN, ALU_FUN}, {1'b1, 1'b1, 4'h9});
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", all_outs(), 32'h0);
    drive(3'b000, 8'h00, 2'b01, 16'h1234);
    chk("rst_held_outs", all_outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 8'h00, 2'b01, 16'h1234);
    drive(3'b000, 8'h00, 2'b00, 16'h0);
    chk("rst_no_resume", {TX_D_VLD, CLKG_EN}, 2'b00);
    drive(3'b100, 8'hAA, 2'b00, 16'h0);
    drive(3'b100, 8'h0F, 2'b00, 16'h0);
    drive(3'b100, 8'hA5, 2'b00, 16'h0);
    chk("post_rst_write", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'hF, 8'hA5});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
